// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: divider state encoding and default width.
package muldiv_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/radix4_digit_select.sv
// Radix-4 restoring digit selection: picks the largest multiple of the divisor
// not exceeding the partial remainder and returns the digit and the new remainder.
module radix4_digit_select
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH+1:0] p,
    input  logic [WIDTH+1:0] d1,
    input  logic [WIDTH+1:0] d2,
    input  logic [WIDTH+1:0] d3,
    output logic [1:0]       digit,
    output logic [WIDTH-1:0] rem_next
);

    localparam int unsigned PW = WIDTH + 2;

    logic [PW-1:0] sub;

    always_comb begin
        digit = 2'd0;
        sub   = '0;
        if (p >= d3) begin
            digit = 2'd3;
            sub   = d3;
        end else if (p >= d2) begin
            digit = 2'd2;
            sub   = d2;
        end else if (p >= d1) begin
            digit = 2'd1;
            sub   = d1;
        end
        // Result is below the divisor, so the top two bits are always zero.
        rem_next = WIDTH'(p - sub);
    end

endmodule

// File: rtl/radix4_divider.sv
// Unsigned iterative radix-4 restoring divider; retires two quotient bits per cycle.
// Responder on the mul/div unit's divide handshake.
module radix4_divider
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             input_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             output_valid,
    output logic             busy
);

    localparam int unsigned ITER  = WIDTH / 2;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned PW    = WIDTH + 2;

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo;
    logic [PW-1:0]    d1, d2, d3;
    logic [PW-1:0]    div_ext;
    logic [PW-1:0]    p;
    logic [1:0]       digit;
    logic [WIDTH-1:0] rem_next;
    logic             load, step;

    assign div_ext = {2'b00, divisor};
    assign p       = {rem, quo[WIDTH-1:WIDTH-2]};

    radix4_digit_select #(.WIDTH(WIDTH)) u_digit_select (
        .p        (p),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .digit    (digit),
        .rem_next (rem_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (input_valid) state_next = DIV_RUN;
            DIV_RUN:  if (cnt == '0)   state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        load         = 1'b0;
        step         = 1'b0;
        output_valid = 1'b0;
        busy         = 1'b0;
        case (state)
            DIV_IDLE: load = input_valid;
            DIV_RUN: begin
                step = 1'b1;
                busy = 1'b1;
            end
            DIV_DONE: begin
                output_valid = 1'b1;
                busy         = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand latch and one radix-4 iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            d1  <= '0;
            d2  <= '0;
            d3  <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            d1  <= div_ext;
            d2  <= div_ext << 1;
            d3  <= div_ext + (div_ext << 1);
            cnt <= CNT_W'(ITER - 1);
        end else if (step) begin
            rem <= rem_next;
            quo <= {quo[WIDTH-3:0], digit};
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule
